sync_fifo_ctl: RTL
==================

# sync_fifo_ctl

Parametrised single-clock FIFO, the same-domain successor to the team's asynchronous FIFO for paths where producer and consumer share one clock. It adds a first-word-fall-through (FWFT) mode and non-power-of-two depth. It also adds almost-full/almost-empty thresholds, a fill-level output and sticky overflow/underflow error flags. It sits between datapath stages as the standard elastic buffer and feeds credit/back-pressure logic through `level`, `afull` and `aempty`.

## Interface
- `DATA_WIDTH`, 32, word width in bits (>=1)
- `FIFO_DEPTH`, 16, number of entries, any integer >=2 (not restricted to powers of two)
- `FWFT`, 0, 0 = standard read (registered, 1-cycle latency); 1 = first-word-fall-through
- `AFULL_TH`, FIFO_DEPTH-2, `afull` asserted when level >= AFULL_TH
- `AEMPTY_TH`, 2, `aempty` asserted when level <= AEMPTY_TH
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset; one clock, reset asynchronous active-high
- `wr_en`  in  1  write request
- `wdata`  in  DATA_WIDTH  write data
- `rd_en`  in  1  read/pop request
- `rdata`  out  DATA_WIDTH  read data
- `rd_valid`  out  1  `rdata` holds a valid word (meaning per mode, below)
- `full` / `empty`  out  1 each  level == FIFO_DEPTH / level == 0
- `afull` / `aempty`  out  1 each  threshold flags
- `level`  out  LVL_W = $clog2(FIFO_DEPTH+1)  current occupancy, 0..FIFO_DEPTH
- `ovf` / `udf`  out  1 each  sticky overflow / underflow error
- `err_clr`  in  1  synchronous clear of `ovf`/`udf`

## Operation
- Write is accepted iff `wr_en && !full`. `wr_en && full` drops the write, leaves state unchanged and sets `ovf`.
- Pop is accepted iff `rd_en && !empty`. `rd_en && empty` is ignored and sets `udf`.
- Accept decisions use flag values before the edge:
  - A write when full is rejected even if a pop occurs in the same cycle.
  - A pop when empty is rejected even if a write occurs in the same cycle.
- Simultaneous accepted write and pop: level unchanged; both pointers advance.
- Pointers are range 0..FIFO_DEPTH-1 and wrap FIFO_DEPTH-1 -> 0 by explicit compare, never by binary overflow.
- `level` is a registered up/down counter: +1 on write only, -1 on pop only.
- `full`, `empty`, `afull`, `aempty` are registered and derived from the next-state level, so they are coherent with `level` every cycle.
- Standard mode (FWFT=0): on an accepted pop, `rdata` is loaded from the head entry and `rd_valid` pulses high for one cycle. `rdata` holds its value otherwise.
- FWFT mode (FWFT=1):
  - `rdata` continuously presents the head entry and `rd_valid` = !empty.
  - `rd_en` acts as acknowledge/pop; the next head appears the cycle after the pop.
- Error flags: set on the event and held until `err_clr`. If an error event and `err_clr` occur in the same cycle, the set wins.
- Memory contents are not reset. In FWFT mode, `rdata` is don't-care while `empty`=1.

## Timing
- Reset values (asserted asynchronously on `rst` high, released on deassertion):
  - pointers = 0, `level` = 0
  - `empty` = 1, `aempty` = 1, `full` = 0, `afull` = 0
  - `rd_valid` = 0, `rdata` = 0 (standard mode), `ovf` = 0, `udf` = 0
- Reset mid-operation discards all content. The first write after release behaves as a write into an empty FIFO.
- Write accepted at edge N:
  - `level`/flags update after edge N.
  - In FWFT mode the word is visible on `rdata` with `rd_valid`=1 in cycle N+1.
- Standard mode: pop accepted at edge N -> `rdata`/`rd_valid` valid in cycle N+1 (1-cycle latency).
- Full throughput: one write and one pop per cycle sustained at any level 1..FIFO_DEPTH-1.

## Structure
- Shared package `fifo_pkg`: mode constants `FIFO_MODE_STD`=0 and `FIFO_MODE_FWFT`=1, plus a level-width helper function `fifo_lvl_w(depth)`.
- One sub-module, `fifo_ram`:
  - FIFO_DEPTH x DATA_WIDTH storage, one write port, one read port.
  - Synchronous write, asynchronous read, no reset.
- The top level holds pointers, counter, flags, error logic and the mode-dependent read stage.

## Test plan
- DEPTH=6, FWFT=0: write 0x11..0x66 -> `full`=1, `level`=6. A 7th write sets `ovf`=1, `level` stays 6. Six pops return 0x11..0x66, each one cycle after `rd_en`; then `empty`=1.
- DEPTH=6: 20 alternating write/pop pairs -> pointers wrap past 5 -> 0; data stays in order; `level` never exceeds 1.
- FWFT=1, DEPTH=8: write 0xA5 at edge N -> `rdata`=0xA5, `rd_valid`=1 in cycle N+1. Pop -> `empty`=1, `rd_valid`=0 next cycle.
- Thresholds with DEPTH=16, AFULL_TH=14, AEMPTY_TH=2: `aempty` falls at level 3 and `afull` rises at level 14. Simultaneous write+pop at level 14 keeps both flags steady.
- Errors: pop when empty sets `udf`=1. Pulsing `err_clr` alone clears it. `err_clr` concurrent with a new underflow leaves `udf`=1.
- Reset with `level`=5 mid-stream -> `level`=0, `empty`=1, `ovf`/`udf`=0. The next write/pop returns only the new data.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: mode constants and
// the occupancy-counter width helper.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int fifo_lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_ctl_if.sv
// FIFO access bundle: master = producer/consumer side,
// slave = FIFO side. Write, pop, status and error signals.
interface sync_fifo_ctl_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LVL_W      = fifo_lvl_w(16)
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rd_en;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  afull;
  logic                  aempty;
  logic [LVL_W-1:0]      level;
  logic                  ovf;
  logic                  udf;

  modport master (
    output wr_en, wdata, rd_en, err_clr,
    input  rdata, rd_valid, full, empty,
    input  afull, aempty, level, ovf, udf
  );

  modport slave (
    input  wr_en, wdata, rd_en, err_clr,
    output rdata, rd_valid, full, empty,
    output afull, aempty, level, ovf, udf
  );
endinterface

// File: rtl/fifo_ram.sv
// FIFO storage: sync write port, async read port, no reset.
// Ports: clk, i_we/i_waddr/i_wdata, i_raddr, o_rdata.
module fifo_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AW         = 4
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO controller, standard or FWFT read.
// Ports: clk, rst (async high), bus (sync_fifo_ctl_if.slave).
module sync_fifo_ctl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int FWFT       = FIFO_MODE_STD,
  parameter int AFULL_TH   = FIFO_DEPTH - 2,
  parameter int AEMPTY_TH  = 2
) (
  input  logic          clk,
  input  logic          rst,
  sync_fifo_ctl_if.slave bus
);
  localparam int LVL_W = fifo_lvl_w(FIFO_DEPTH);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_MAX =
    PTR_W'(FIFO_DEPTH - 1);

  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [LVL_W-1:0]      r_level;
  logic [LVL_W-1:0]      w_lvl_nxt;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_afull;
  logic                  r_aempty;
  logic                  r_ovf;
  logic                  r_udf;
  logic                  w_wr;
  logic                  w_rd;
  logic [DATA_WIDTH-1:0] w_head;

  // Accept decisions use the flags from before the edge.
  assign w_wr = bus.wr_en && !r_full;
  assign w_rd = bus.rd_en && !r_empty;

  always_comb begin
    w_lvl_nxt = r_level;
    unique case ({w_wr, w_rd})
      2'b10:   w_lvl_nxt = r_level + LVL_W'(1);
      2'b01:   w_lvl_nxt = r_level - LVL_W'(1);
      default: w_lvl_nxt = r_level;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wr)
        r_wptr <= (r_wptr == PTR_MAX) ? '0
                : r_wptr + PTR_W'(1);
      if (w_rd)
        r_rptr <= (r_rptr == PTR_MAX) ? '0
                : r_rptr + PTR_W'(1);
      r_level  <= w_lvl_nxt;
      r_full   <= w_lvl_nxt == LVL_W'(FIFO_DEPTH);
      r_empty  <= w_lvl_nxt == '0;
      r_afull  <= w_lvl_nxt >= LVL_W'(AFULL_TH);
      r_aempty <= w_lvl_nxt <= LVL_W'(AEMPTY_TH);
      // A new error event beats a same-cycle clear.
      r_ovf <= (bus.wr_en && r_full)
             || (r_ovf && !bus.err_clr);
      r_udf <= (bus.rd_en && r_empty)
             || (r_udf && !bus.err_clr);
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .AW         (PTR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr),
    .i_waddr (r_wptr),
    .i_wdata (bus.wdata),
    .i_raddr (r_rptr),
    .o_rdata (w_head)
  );

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      assign bus.rdata    = w_head;
      assign bus.rd_valid = !r_empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] r_rdata;
      logic                  r_rd_valid;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_rdata    <= '0;
          r_rd_valid <= 1'b0;
        end else begin
          r_rd_valid <= w_rd;
          if (w_rd) r_rdata <= w_head;
        end
      end

      assign bus.rdata    = r_rdata;
      assign bus.rd_valid = r_rd_valid;
    end
  endgenerate

  assign bus.full   = r_full;
  assign bus.empty  = r_empty;
  assign bus.afull  = r_afull;
  assign bus.aempty = r_aempty;
  assign bus.level  = r_level;
  assign bus.ovf    = r_ovf;
  assign bus.udf    = r_udf;
endmodule
